// File: rtl/sa_pkg.sv
// sa_pkg: state encoding and default sizing shared by the systolic-array controller
package sa_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} sa_ctrl_state_t;
    localparam int SA_SIZE  = 32;
    localparam int SA_WIDTH = 8;
    localparam int SA_MAX_K = 256;
endpackage

// File: rtl/sa_controller.sv
// sa_controller: sequences clear, feed, drain and done phases of one SIZE x SIZE systolic-array job
//   start/k_len request a job (IDLE only), abort cancels it, out_ready paces the result drain.
//   busy/done/err report status; sa_load/sa_clear/sa_carry_en drive the array;
//   buf_rd_en/buf_rd_addr stream the operand buffers; out_valid/out_col present result columns.
module sa_controller
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE,
    parameter int MAX_K = SA_MAX_K
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MAX_K+1)-1:0]   k_len,
    input  logic                         abort,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         sa_load,
    output logic                         sa_clear,
    output logic                         sa_carry_en [SIZE],
    output logic                         buf_rd_en,
    output logic [$clog2(MAX_K)-1:0]     buf_rd_addr,
    output logic                         out_valid,
    output logic [$clog2(SIZE)-1:0]      out_col
);
    localparam int KW = $clog2(MAX_K+1);
    localparam int AW = $clog2(MAX_K);
    localparam int CW = $clog2(MAX_K+2*SIZE);
    localparam int OW = $clog2(SIZE);
    if (WIDTH < 1 || SIZE < 2) begin : g_bad_params
        $error("sa_controller: WIDTH must be >= 1 and SIZE >= 2");
    end
    sa_ctrl_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [KW-1:0] k_reg;
    logic k_ok, feed_end, rd_n;
    assign k_ok = k_len != '0 && k_len <= KW'(MAX_K);
    // FEED runs k_len + 2*SIZE - 2 cycles so the skewed wavefront fully fills and flushes
    assign feed_end = cnt == CW'(k_reg) + CW'(2*SIZE-3);
    assign rd_n = state_n == FEED && cnt_n < CW'(k_reg);
    always_comb begin
        state_n = state;
        cnt_n = '0;
        if (state != IDLE && abort)
            state_n = IDLE;
        else
            case (state)
                IDLE:  state_n = start && k_ok && !abort ? CLEAR : IDLE;
                CLEAR: state_n = FEED;
                FEED: begin
                    state_n = feed_end ? DRAIN : FEED;
                    cnt_n = feed_end ? '0 : cnt + 1'b1;
                end
                DRAIN: begin
                    state_n = out_ready && cnt == CW'(SIZE-1) ? DONE : DRAIN;
                    cnt_n = !out_ready ? cnt : cnt == CW'(SIZE-1) ? '0 : cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
    end
    // Outputs are decoded from the next state so they line up with the registered state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            k_reg <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            sa_load <= 1'b0;
            sa_clear <= 1'b0;
            buf_rd_en <= 1'b0;
            buf_rd_addr <= '0;
            out_valid <= 1'b0;
            out_col <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (state == IDLE && state_n == CLEAR) k_reg <= k_len;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            err <= state == IDLE && start && !k_ok && !abort;
            sa_load <= state_n == FEED;
            sa_clear <= state_n == CLEAR;
            buf_rd_en <= rd_n;
            buf_rd_addr <= rd_n ? cnt_n[AW-1:0] : '0;
            out_valid <= state_n == DRAIN;
            out_col <= state_n == DRAIN ? OW'(SIZE-1) - cnt_n[OW-1:0] : '0;
        end
    end
    // Column shift must react to out_ready in the same cycle, so this one stays combinational
    always_comb
        for (int j = 0; j < SIZE; j++) sa_carry_en[j] = state == DRAIN && out_ready;
endmodule

// File: tb/tb_sa_controller.sv
// tb_sa_controller: randomized and directed self-checking bench for sa_controller (SIZE=4, MAX_K=16)
module tb_sa_controller;
    localparam int SIZE = 4;
    localparam int MAX_K = 16;
    localparam int WIDTH = 8;
    logic clk = 1'b0;
    logic reset, start, abort, out_ready;
    logic [4:0] k_len;
    logic busy, done, err, sa_load, sa_clear, buf_rd_en, out_valid;
    logic sa_carry_en [SIZE];
    logic [3:0] buf_rd_addr;
    logic [1:0] out_col;
    logic [16:0] obs;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    sa_controller #(.WIDTH(WIDTH), .SIZE(SIZE), .MAX_K(MAX_K)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .abort(abort), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .sa_load(sa_load), .sa_clear(sa_clear),
        .sa_carry_en(sa_carry_en), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .out_valid(out_valid), .out_col(out_col)
    );
    assign obs = {busy, done, err, sa_load, sa_clear, buf_rd_en, buf_rd_addr, out_valid, out_col,
                  sa_carry_en[3], sa_carry_en[2], sa_carry_en[1], sa_carry_en[0]};
    function automatic logic [16:0] expv(input bit b, input bit d, input bit e, input bit l, input bit c,
                                         input bit rd, input logic [3:0] a, input bit v,
                                         input logic [1:0] col, input logic [3:0] ce);
        return {b, d, e, l, c, rd, a, v, col, ce};
    endfunction
    task automatic test_reset;
        reset = 1; start = 1; k_len = 5'd3; abort = 0; out_ready = 1;
        repeat (3) begin
            @(negedge clk); #1;
            tests++;
            if (obs !== 17'h0) begin fails++; $display("FAIL reset_hold got=%h want=%h", obs, 17'h0); end
        end
        reset = 0; start = 0;
        @(negedge clk); #1;
        tests++;
        if (obs !== 17'h0) begin fails++; $display("FAIL reset_release got=%h want=%h", obs, 17'h0); end
    endtask
    // Timeline model: clear at t=1, feed for k+2S-2 cycles, drain until SIZE accepted beats, then done
    task automatic run_job(input int k, input bit rnd, input int abort_t, input string name);
        int beats, fl, t;
        bit r, fin, drain;
        logic [16:0] e;
        fl = k + 2*SIZE - 2; beats = 0; fin = 0;
        @(negedge clk); start = 1; k_len = 5'(k); abort = 0;
        @(negedge clk);
        for (t = 1; t < 400 && !fin; t++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            abort = (t == abort_t);
            start = 1'($urandom_range(0, 1));
            k_len = 5'($urandom_range(0, 31));
            #1;
            drain = 0;
            if (t == 1) e = expv(1, 0, 0, 0, 1, 0, 4'd0, 0, 2'd0, 4'd0);
            else if (t <= fl + 1) e = expv(1, 0, 0, 1, 0, t - 2 < k, t - 2 < k ? 4'(t - 2) : 4'd0, 0, 2'd0, 4'd0);
            else if (beats < SIZE) begin
                e = expv(1, 0, 0, 0, 0, 0, 4'd0, 1, 2'(SIZE - 1 - beats), {4{r}});
                drain = 1;
            end else begin
                e = expv(1, 1, 0, 0, 0, 0, 4'd0, 0, 2'd0, 4'd0);
                fin = 1;
            end
            tests++;
            if (obs !== e) begin fails++; $display("FAIL %s k=%0d t=%0d got=%h want=%h", name, k, t, obs, e); end
            if (drain && r) beats++;
            if (abort) fin = 1;
            @(negedge clk);
        end
        tests++;
        if (!fin) begin fails++; $display("FAIL %s_timeout k=%0d got=%0d want=done", name, k, t); end
        start = 0; abort = 0; out_ready = 1; #1;
        tests++;
        if (obs !== 17'h0) begin fails++; $display("FAIL %s_idle k=%0d got=%h want=%h", name, k, obs, 17'h0); end
    endtask
    task automatic test_job_latency(input int k, input int exp_lat);
        int lat, loads, clears, t;
        bit seq_ok;
        int addr_q[$];
        int col_q[$];
        lat = -1; loads = 0; clears = 0; seq_ok = 1;
        @(negedge clk); start = 1; k_len = 5'(k); out_ready = 1; abort = 0;
        @(negedge clk); start = 0;
        for (t = 1; t <= 100 && lat < 0; t++) begin
            #1;
            if (sa_load) loads++;
            if (sa_clear) clears++;
            if (buf_rd_en) addr_q.push_back(int'(buf_rd_addr));
            if (out_valid) col_q.push_back(int'(out_col));
            if (done) lat = t;
            @(negedge clk);
        end
        tests++;
        if (lat !== exp_lat) begin fails++; $display("FAIL latency k=%0d got=%0d want=%0d", k, lat, exp_lat); end
        tests++;
        if (loads !== k + 2*SIZE - 2) begin fails++; $display("FAIL load_cycles k=%0d got=%0d want=%0d", k, loads, k + 2*SIZE - 2); end
        tests++;
        if (clears !== 1) begin fails++; $display("FAIL clear_cycles k=%0d got=%0d want=1", k, clears); end
        if (addr_q.size() != k) seq_ok = 0;
        foreach (addr_q[i]) if (addr_q[i] != i) seq_ok = 0;
        tests++;
        if (!seq_ok) begin fails++; $display("FAIL addr_seq k=%0d got=%p want=0..%0d", k, addr_q, k - 1); end
        seq_ok = col_q.size() == SIZE;
        foreach (col_q[i]) if (col_q[i] != SIZE - 1 - i) seq_ok = 0;
        tests++;
        if (!seq_ok) begin fails++; $display("FAIL col_seq k=%0d got=%p want=3,2,1,0", k, col_q); end
    endtask
    task automatic test_stall;
        int k, stall_t, done_t, t;
        k = 3; stall_t = k + 2*SIZE + 1; done_t = -1;
        @(negedge clk); start = 1; k_len = 5'(k); out_ready = 1;
        @(negedge clk); start = 0;
        for (t = 1; t <= 60 && done_t < 0; t++) begin
            out_ready = !(t == stall_t || t == stall_t + 1);
            #1;
            if (t >= stall_t && t <= stall_t + 2) begin
                tests++;
                if (out_valid !== 1'b1 || out_col !== 2'd2 || obs[3:0] !== {4{out_ready}} || sa_load !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_hold t=%0d got=v%b col%0d ce%h want=v1 col2 ce%h", t, out_valid, out_col, obs[3:0], {4{out_ready}});
                end
            end
            if (done) done_t = t;
            @(negedge clk);
        end
        out_ready = 1;
        tests++;
        if (done_t !== 17) begin fails++; $display("FAIL stall_latency got=%0d want=17", done_t); end
    endtask
    task automatic test_err;
        logic [4:0] bad[$];
        bad = {5'd0, 5'd17};
        repeat (4) bad.push_back(5'($urandom_range(17, 31)));
        foreach (bad[i]) begin
            @(negedge clk); start = 1; k_len = bad[i];
            @(negedge clk); start = 0; #1;
            tests++;
            if (obs !== expv(0, 0, 1, 0, 0, 0, 4'd0, 0, 2'd0, 4'd0)) begin
                fails++; $display("FAIL err_pulse k=%0d got=%h want=%h", bad[i], obs, expv(0, 0, 1, 0, 0, 0, 4'd0, 0, 2'd0, 4'd0));
            end
            @(negedge clk); #1;
            tests++;
            if (obs !== 17'h0) begin fails++; $display("FAIL err_after k=%0d got=%h want=%h", bad[i], obs, 17'h0); end
        end
    endtask
    task automatic test_abort;
        run_job(5, 0, 6, "abort_feed");
        test_job_latency(1, 13);
    endtask
    task automatic test_random;
        int k, a;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(1, 16);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k + 3*SIZE) : 0;
            run_job(k, 1, a, "rand_job");
        end
    endtask
    task automatic test_reset_mid_job;
        int t;
        @(negedge clk); start = 1; k_len = 5'd3; out_ready = 1;
        @(negedge clk); start = 0;
        for (t = 0; t < 40 && out_valid !== 1'b1; t++) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL reset_drain_reach got=%b want=1", out_valid); end
        reset = 1; start = 1; k_len = 5'd4;
        repeat (3) begin
            @(negedge clk); #1;
            tests++;
            if (obs !== 17'h0) begin fails++; $display("FAIL reset_drain got=%h want=%h", obs, 17'h0); end
        end
        reset = 0; start = 0;
        repeat (20) begin
            @(negedge clk); #1;
            tests++;
            if (obs !== 17'h0) begin fails++; $display("FAIL reset_discard got=%h want=%h", obs, 17'h0); end
        end
    endtask
    task automatic test_back_to_back;
        int d0, d1, dn, c1, cn, idle_t;
        d0 = -1; d1 = -1; dn = 0; c1 = -1; cn = 0; idle_t = -1;
        @(negedge clk); start = 1; k_len = 5'd2; out_ready = 1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk); #1;
            if (done) begin if (dn == 0) d0 = t; else d1 = t; dn++; end
            if (sa_clear) begin if (cn == 1) c1 = t; cn++; end
            if (!busy && idle_t < 0) idle_t = t;
            if (t == 29) start = 0;
        end
        tests++;
        if (dn !== 2 || d0 !== 14 || d1 !== 29) begin fails++; $display("FAIL b2b_done got=%0d@%0d,%0d want=2@14,29", dn, d0, d1); end
        tests++;
        if (idle_t !== 15) begin fails++; $display("FAIL b2b_idle got=%0d want=15", idle_t); end
        tests++;
        if (c1 !== 16) begin fails++; $display("FAIL b2b_restart got=%0d want=16", c1); end
    endtask
    initial begin
        reset = 1; start = 0; abort = 0; out_ready = 1; k_len = 5'd0;
        test_reset;
        test_job_latency(3, 15);
        test_stall;
        test_err;
        test_abort;
        test_random;
        test_reset_mid_job;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
